qpu_mcu_meas_collect: RTL

QPU_MCU_MEAS_COLLECT -- requirements
Module: qpu_mcu_meas_collect

---
 rtl/qpu_meas_pkg.sv | 19 +
 rtl/qpu_meas_tmo_cnt.sv | 33 +++
 rtl/qpu_mcu_meas_collect.sv | 126 ++++++++++++
 3 files changed

// File: rtl/qpu_meas_pkg.sv
// Shared types and width helpers for the measurement-collect block.
// Both helpers clamp to 1 so degenerate parameters still give legal vectors.
package qpu_meas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WBCK
    } meas_st_e;

    function automatic int qidx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int tmo_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/qpu_meas_tmo_cnt.sv
// Idle-cycle counter for the collect phase.
// o_tc fires on the increment that brings the count to TMO_CYC-1.
module qpu_meas_tmo_cnt
    import qpu_meas_pkg::*;
#(
    parameter int TMO_CYC = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int CNT_W = tmo_w(TMO_CYC);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Compare against the pre-increment value so the forced writeback
    // lands exactly TMO_CYC cycles after the last activity.
    assign o_tc = i_en && (r_cnt == CNT_W'(TMO_CYC - 2));

endmodule

// File: rtl/qpu_mcu_meas_collect.sv
// Collects per-qubit readout results for one measurement batch and writes
// the assembled word to the result register file, with idle timeout.
module qpu_mcu_meas_collect
    import qpu_meas_pkg::*;
#(
    parameter  int QUBIT_NUM = 12,
    parameter  int TMO_CYC   = 1023,
    localparam int QIDX_W    = qidx_w(QUBIT_NUM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 meas_req_valid,
    input  logic [QUBIT_NUM-1:0] meas_req_list,
    output logic                 meas_req_ready,
    input  logic                 rd_valid,
    input  logic [QIDX_W-1:0]    rd_idx,
    input  logic                 rd_result,
    output logic                 mcu_measure_o_wen,
    output logic [QUBIT_NUM-1:0] mcu_measure_o_data,
    output logic [QUBIT_NUM-1:0] mcu_measure_o_list,
    output logic                 timeout_err,
    output logic                 unexp_err
);

    meas_st_e r_state, w_state_nxt;

    logic [QUBIT_NUM-1:0] r_pending, r_list, r_data;
    logic [QUBIT_NUM-1:0] w_pend_nxt, w_data_nxt;
    logic [QUBIT_NUM-1:0] r_out_data, r_out_list;
    logic                 r_wen, r_tmo_err, r_unexp;

    logic w_idx_ok, w_hit, w_accept, w_tmo_en, w_tc;
    logic w_to_wbck, w_timeout;

    assign w_idx_ok = 32'(rd_idx) < QUBIT_NUM;
    assign w_hit    = (r_state == ST_COLLECT) && rd_valid && w_idx_ok && r_pending[rd_idx];
    assign w_accept = (r_state == ST_IDLE) && meas_req_valid && (|meas_req_list);
    assign w_tmo_en = (r_state == ST_COLLECT) && !w_hit;

    qpu_meas_tmo_cnt #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_accept || w_hit),
        .i_en  (w_tmo_en),
        .o_tc  (w_tc)
    );

    always_comb begin
        w_pend_nxt = r_pending;
        w_data_nxt = r_data;
        if (w_accept) begin
            w_pend_nxt = meas_req_list;
            w_data_nxt = '0;
        end else if (w_hit) begin
            w_pend_nxt[rd_idx] = 1'b0;
            w_data_nxt[rd_idx] = rd_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // A completing result wins over a timeout in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_to_wbck   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (w_hit && (w_pend_nxt == '0)) begin
                    w_state_nxt = ST_WBCK;
                    w_to_wbck   = 1'b1;
                end else if (w_tc) begin
                    w_state_nxt = ST_WBCK;
                    w_to_wbck   = 1'b1;
                    w_timeout   = 1'b1;
                end
            end
            ST_WBCK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Write strobe is registered on the edge entering WBCK so it is
    // visible during the WBCK cycle itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_list     <= '0;
            r_data     <= '0;
            r_wen      <= 1'b0;
            r_out_data <= '0;
            r_out_list <= '0;
            r_tmo_err  <= 1'b0;
            r_unexp    <= 1'b0;
        end else begin
            r_pending  <= w_pend_nxt;
            r_data     <= w_data_nxt;
            if (w_accept) r_list <= meas_req_list;
            r_wen      <= w_to_wbck;
            r_out_data <= w_to_wbck ? w_data_nxt : '0;
            r_out_list <= w_to_wbck ? r_list : '0;
            r_tmo_err  <= w_timeout;
            r_unexp    <= rd_valid && !w_hit;
        end
    end

    assign meas_req_ready     = (r_state == ST_IDLE);
    assign mcu_measure_o_wen  = r_wen;
    assign mcu_measure_o_data = r_out_data;
    assign mcu_measure_o_list = r_out_list;
    assign timeout_err        = r_tmo_err;
    assign unexp_err          = r_unexp;

endmodule
